// File: rtl/attempt_guard_if.sv
// rtl/attempt_guard_if.sv - comparator-side strobes and lock-side status of the attempt guard
interface attempt_guard_if #(
  parameter int MAX_ERRORS = 3
);
  localparam int CNT_W = $clog2(MAX_ERRORS + 1);

  logic             check_valid;
  logic             correct;
  logic [CNT_W-1:0] error_count;
  logic             locked;
  logic             alarm;
  logic             accept;

  modport master (
    output check_valid, correct,
    input  error_count, locked, alarm, accept
  );

  modport slave (
    input  check_valid, correct,
    output error_count, locked, alarm, accept
  );
endinterface

// File: rtl/attempt_guard.sv
// rtl/attempt_guard.sv - wrong-code counter with timed lockout; LOCKOUT_ESCALATE_EN doubles each lockout
module attempt_guard #(
  parameter int MAX_ERRORS  = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input logic             clk,
  input logic             rst,
  attempt_guard_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_ERRORS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_ERRORS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_ERRORS - 1);
  localparam logic [31:0]      LOCK_BASE = 32'(LOCK_CYCLES);

  if (MAX_ERRORS < 1 || MAX_ERRORS > 15) begin : g_bad_max_errors
    $error("attempt_guard: MAX_ERRORS must be 1..15");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock_min
    $error("attempt_guard: LOCK_CYCLES must be >= 1");
  end
  // Headroom for the largest escalated duration (LOCK_CYCLES << 3).
  if (longint'(LOCK_CYCLES) * 64'd8 >= 64'h1_0000_0000) begin : g_bad_lock_max
    $error("attempt_guard: LOCK_CYCLES*8 must fit in 32 bits");
  end

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [31:0]      timer;
  logic [31:0]      lock_dur;
  logic             locked_q;
  logic             alarm_q;

`ifdef LOCKOUT_ESCALATE_EN
  logic [1:0] level;
  assign lock_dur = LOCK_BASE << level;
`else
  assign lock_dur = LOCK_BASE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      timer    <= '0;
      locked_q <= 1'b0;
      alarm_q  <= 1'b0;
`ifdef LOCKOUT_ESCALATE_EN
      level    <= 2'd0;
`endif
    end else begin
      alarm_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.check_valid) begin
            if (bus.correct) begin
              count <= '0;
`ifdef LOCKOUT_ESCALATE_EN
              level <= 2'd0;
`endif
            end else if (count == LAST_CNT) begin
              count    <= MAX_CNT;
              locked_q <= 1'b1;
              alarm_q  <= 1'b1;
              timer    <= lock_dur - 32'd1;
              state    <= LOCKED;
`ifdef LOCKOUT_ESCALATE_EN
              level    <= (level == 2'd3) ? 2'd3 : level + 2'd1;
`endif
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        LOCKED: begin
          // Strobes are deliberately ignored here, including on the exit cycle.
          if (timer == 32'd0) begin
            state    <= IDLE;
            locked_q <= 1'b0;
            count    <= '0;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.error_count = count;
  assign bus.locked      = locked_q;
  assign bus.alarm       = alarm_q;
  assign bus.accept      = !locked_q;
endmodule
